fir_filter_mac: RTL and testbench

- Parametrised FIR filter for signed samples, the next generation of our fixed 4-tap filter.
- Uses a single time-multiplexed multiply-accumulate, one tap per cycle.
- Adds valid/ready handshakes, a double-buffered coefficient bank, rounding, saturation and a bypass mode.
- Sits between the input sample source and the output register / display path of the top-level.

---
 rtl/fir_pkg.sv | 47 ++++
 rtl/fir_coef_bank.sv | 41 ++++
 rtl/fir_filter_mac.sv | 117 +++++++++++
 tb/tb_fir_filter_mac.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and the round/saturate helper for the time-multiplexed FIR filter.
// The helper works on a wide signed word so that any accumulator width fits.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int SAT_W = 64;

    typedef struct packed {
        logic             sat;
        logic [SAT_W-1:0] value;
    } sat_round_t;

    // Round half up (toward +inf), then clip to a signed data_w-bit range.
    function automatic sat_round_t sat_round(
        input logic signed [SAT_W-1:0] acc,
        input int                      out_shift,
        input int                      data_w
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] half;
        logic signed [SAT_W-1:0] r;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_round_t              res;
        one  = {{(SAT_W-1){1'b0}}, 1'b1};
        half = one <<< (out_shift - 1);
        r    = (acc + half) >>> out_shift;
        hi   = (one <<< (data_w - 1)) - one;
        lo   = -(one <<< (data_w - 1));
        res.sat   = 1'b0;
        res.value = r;
        if (r > hi) begin
            res.sat   = 1'b1;
            res.value = hi;
        end else if (r < lo) begin
            res.sat   = 1'b1;
            res.value = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank, and the
// active bank used by the MAC is refreshed from the shadow on each copy strobe.
module fir_coef_bank #(
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    localparam int ADDR_W = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic signed [COEF_W-1:0] wdata,
    input  logic                     copy,
    input  logic [ADDR_W-1:0]        raddr,
    output logic signed [COEF_W-1:0] rdata
);

    logic signed [COEF_W-1:0] shadow [TAPS];
    logic signed [COEF_W-1:0] active [TAPS];

    // The copy reads the shadow as it stood at the start of the cycle, so a
    // write coinciding with a copy only reaches the following sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            if (we && (int'(waddr) < TAPS))
                shadow[waddr] <= wdata;
            if (copy) begin
                for (int k = 0; k < TAPS; k++)
                    active[k] <= shadow[k];
            end
        end
    end

    assign rdata = active[raddr];

endmodule

// File: rtl/fir_filter_mac.sv
// Signed FIR filter with one shared multiply-accumulate stepping through one tap
// per cycle, valid/ready handshakes, rounding, saturation and a bypass path.
module fir_filter_mac
    import fir_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 4,
    parameter int OUT_SHIFT = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    input  logic                       bypass,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_data,
    output logic                       sat_flag,
    output logic                       busy
);

    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);

    state_t                    state;
    state_t                    state_next;
    logic signed [DATA_W-1:0]  x [TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [PROD_W-1:0]  prod;
    logic signed [COEF_W-1:0]  coef;
    logic [ADDR_W-1:0]         tap;
    logic                      accept;
    logic                      last_tap;
    sat_round_t                rnd;
    logic                      rnd_unused;

    assign accept   = (state == IDLE) && in_valid;
    assign last_tap = (tap == ADDR_W'(TAPS - 1));

    fir_coef_bank #(
        .COEF_W (COEF_W),
        .TAPS   (TAPS)
    ) u_coef_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (coef_we),
        .waddr (coef_addr),
        .wdata (coef_wdata),
        .copy  (accept),
        .raddr (tap),
        .rdata (coef)
    );

    // The last tap's product feeds the rounder directly so the result is
    // registered in the same cycle the final accumulation happens.
    always_comb begin
        prod    = coef * x[tap];
        acc_sum = acc + ACC_W'(prod);
        rnd     = sat_round(SAT_W'(acc_sum), OUT_SHIFT, DATA_W);
    end

    assign rnd_unused = ^rnd.value[SAT_W-1:DATA_W];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = bypass ? OUT : MAC;
            MAC:     if (last_tap) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            tap      <= '0;
            out_data <= '0;
            sat_flag <= 1'b0;
            for (int k = 0; k < TAPS; k++)
                x[k] <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                x[0] <= in_data;
                for (int k = TAPS - 1; k > 0; k--)
                    x[k] <= x[k-1];
                acc <= '0;
                tap <= '0;
                if (bypass) begin
                    out_data <= in_data;
                    sat_flag <= 1'b0;
                end
            end else if (state == MAC) begin
                acc <= acc_sum;
                tap <= tap + ADDR_W'(1);
                if (last_tap) begin
                    out_data <= rnd.value[DATA_W-1:0];
                    sat_flag <= rnd.sat;
                end
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fir_filter_mac.sv
// Directed bench for fir_filter_mac: impulse response, saturation, latency with
// backpressure, coefficient shadowing, bypass and reset in the middle of a MAC.
module tb_fir_filter_mac;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              coef_we = 1'b0;
    logic [1:0]        coef_addr = '0;
    logic signed [7:0] coef_wdata = '0;
    logic              bypass = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic signed [7:0] out_data;
    logic              sat_flag;
    logic              busy;

    int checks = 0;
    int errors = 0;
    logic signed [7:0] d;
    logic              s;
    int t1_in  [4] = '{100, 0, 0, 0};
    int t1_exp [4] = '{50, 25, 13, 6};

    fir_filter_mac #(
        .DATA_W    (8),
        .COEF_W    (8),
        .TAPS      (4),
        .OUT_SHIFT (7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .bypass     (bypass),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .sat_flag   (sat_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_coef(input int a, input int v);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 2'(a);
        coef_wdata = 8'(v);
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
        write_coef(0, c0);
        write_coef(1, c1);
        write_coef(2, c2);
        write_coef(3, c3);
    endtask

    task automatic send(input int smp, input logic byp);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 8'(smp);
        bypass   = byp;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bypass   = 1'b0;
    endtask

    task automatic get_out(output logic signed [7:0] od, output logic os);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_timeout", out_valid, 1);
        od = out_data;
        os = sat_flag;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        do_reset();

        // 1: impulse response
        set_coefs(64, 32, 16, 8);
        for (int i = 0; i < 4; i++) begin
            send(t1_in[i], 1'b0);
            get_out(d, s);
            check("impulse_data", d, t1_exp[i]);
            check("impulse_sat", s, 0);
        end

        // 2: positive saturation
        set_coefs(127, 127, 127, 127);
        for (int i = 0; i < 4; i++) begin
            send(127, 1'b0);
            get_out(d, s);
            if (i == 0) begin
                check("pos_first_data", d, 126);
                check("pos_first_sat", s, 0);
            end
        end
        check("pos_sat_data", d, 127);
        check("pos_sat_flag", s, 1);

        // 3: negative saturation
        for (int i = 0; i < 4; i++) begin
            send(-128, 1'b0);
            get_out(d, s);
        end
        check("neg_sat_data", d, -128);
        check("neg_sat_flag", s, 1);

        // 4: latency and backpressure
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(-128, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("lat_no_valid", out_valid, 0);
            check("lat_in_ready_mac", in_ready, 0);
        end
        for (int c = 5; c <= 9; c++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, -128);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        check("bp_valid_c10", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_busy", busy, 0);
        check("bp_idle_in_ready", in_ready, 1);

        // 5: coefficient shadowing and bypass
        do_reset();
        set_coefs(64, 32, 16, 8);
        send(100, 1'b0);
        write_coef(0, 0);
        get_out(d, s);
        check("shadow_cur", d, 50);
        send(100, 1'b0);
        get_out(d, s);
        check("shadow_next", d, 25);
        send(-7, 1'b1);
        @(negedge clk);
        check("bypass_valid", out_valid, 1);
        check("bypass_data", out_data, -7);
        check("bypass_sat", sat_flag, 0);
        @(posedge clk);

        // 6: reset during MAC
        do_reset();
        set_coefs(64, 32, 16, 8);
        send(100, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        send(100, 1'b0);
        get_out(d, s);
        check("midrst_next_data", d, 0);
        check("midrst_next_sat", s, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
